md5_dsm_writer: RTL
===================

# md5_dsm_writer

Host-facing status write-back engine for the MD5 AFU. The CSR block carries host-to-AFU configuration: DSM base address and job control. This block carries the reverse path. On each job-completion event it writes one 64-byte status line (flags, sequence number, job id, digest) to host memory at the DSM base over CCI-P channel 1. It then waits for the matching write response, with almost-full backpressure, one-deep event buffering and a response timeout.

## Interface
- TIMEOUT_CYCLES, 4096: max cycles to wait for a write response before abandoning.
- MDATA_TAG, 8'hD5: upper byte of mdata used to tag this block's writes.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- dsm_base  in  42  DSM cache-line address (byte address >> 6); 0 = write-back disabled.
- done_valid  in  1  one-cycle job-completion pulse.
- done_job_id  in  32  job id, sampled with done_valid.
- done_error  in  1  job error flag, sampled with done_valid.
- done_digest  in  128  MD5 digest, sampled with done_valid.
- c1_tx_almfull  in  1  channel-1 TX almost full.
- c1_tx_valid  out  1  write request valid (registered).
- c1_tx_addr  out  42  write cache-line address.
- c1_tx_mdata  out  16  request tag.
- c1_tx_data  out  512  status line.
- c1_rx_wrrsp_valid  in  1  write response valid.
- c1_rx_mdata  in  16  response tag.
- busy  out  1  FSM not IDLE or pending event held.
- wr_seq  out  32  completed write count.
- overflow  out  1  sticky: event dropped because buffer full.
- timeout  out  1  sticky: response timeout occurred.

## Operation
- Reset values: all outputs 0; FSM IDLE; pending buffer empty; timer 0.
- Event capture: a done_valid pulse latches {job_id, error, digest} into the active slot if FSM is IDLE and the slot is empty. Otherwise it goes to the one-deep pending slot. If the pending slot is also full, the event is dropped and overflow is set.
- FSM states: IDLE, ISSUE, WAIT_RSP.
  - IDLE -> ISSUE: when an event is held. The pending slot moves to the active slot on this transition.
  - ISSUE: if dsm_base == 0, discard the event; no write; wr_seq unchanged; return to IDLE.
  - ISSUE: else, when c1_tx_almfull == 0, drive c1_tx_valid for exactly one cycle, then go to WAIT_RSP.
  - ISSUE: while almfull == 1, hold in ISSUE with c1_tx_valid = 0.
  - WAIT_RSP -> IDLE: on c1_rx_wrrsp_valid with c1_rx_mdata == {MDATA_TAG, wr_seq[7:0]}. wr_seq increments, wrapping 2^32-1 -> 0.
  - WAIT_RSP -> IDLE on timeout: timer reaches TIMEOUT_CYCLES-1 without a match. Sets timeout; wr_seq unchanged.
- Responses with a non-matching mdata are ignored in every state.
- Status line layout in c1_tx_data:
  - [0] = 1 (done).
  - [1] = error.
  - [31:2] = 0.
  - [63:32] = wr_seq + 1 (value after completion).
  - [95:64] = job_id.
  - [127:96] = 0.
  - [255:128] = digest.
  - [511:256] = 0.
- c1_tx_addr = dsm_base sampled in ISSUE; c1_tx_mdata = {MDATA_TAG, wr_seq[7:0]}.
- Simultaneous events:
  - done_valid in the same cycle a matching response returns: the new event goes to the pending slot, or to active if the pending slot is empty and the FSM is reaching IDLE. It is never lost unless both slots are full.
  - Response in the same cycle as the timer expiry: the response wins; timeout is not set.
- reset_n assertion mid-operation: immediate return to reset values. A response arriving after reset release is ignored as unmatched.

## Timing
- done_valid in cycle N, FSM IDLE, almfull low:
  - ISSUE in N+1.
  - c1_tx_valid high in N+2 only.
  - WAIT_RSP from N+3.
- Response in cycle M: wr_seq updated and busy low in M+1, if no pending event.
- Back-to-back: a pending event reaches ISSUE the cycle after return to IDLE.
- The timer starts at 0 on entry to WAIT_RSP and counts one per cycle.
- Throughput: at most one outstanding write.

## Test plan
- Single write: dsm_base = 42'h100, done_valid with job_id 7, digest 128'hA5..A5, error 0.
  - c1_tx_valid once, addr 42'h100, mdata 16'hD500, data[63:0] = 64'h0000_0001_0000_0001.
  - After response mdata 16'hD500: wr_seq = 1, busy = 0.
- Backpressure: hold c1_tx_almfull high for 10 cycles after the event.
  - No c1_tx_valid during those cycles.
  - valid exactly one cycle after almfull drops.
- Buffering and overflow: three done pulses on consecutive cycles while the first write is outstanding.
  - Two writes are issued in order.
  - The third event is dropped and overflow = 1.
- Timeout: TIMEOUT_CYCLES = 16, no response.
  - timeout = 1 at cycle 16 of WAIT_RSP; wr_seq = 0; FSM IDLE.
  - A late response with mdata D500 is ignored.
- Disabled and wrap: dsm_base = 0 with a done pulse.
  - No c1_tx_valid and wr_seq unchanged.
  - Force wr_seq = 32'hFFFF_FFFF, then complete one write: data[63:32] = 0 and wr_seq = 0.
- Async reset: assert reset_n low in WAIT_RSP.
  - All outputs 0 immediately, without waiting for a clock edge.
  - A matching response after release is ignored.

Source files
------------

// File: rtl/md5_dsm_writer.sv
// Writes a 64-byte job status line to the host DSM area on each job completion,
// then waits for the tagged write response. Holds one pending event and gives up after a response timeout.
module md5_dsm_writer #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [7:0]  MDATA_TAG      = 8'hD5
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [41:0]    dsm_base,
  input  logic           done_valid,
  input  logic [31:0]    done_job_id,
  input  logic           done_error,
  input  logic [127:0]   done_digest,
  input  logic           c1_tx_almfull,
  output logic           c1_tx_valid,
  output logic [41:0]    c1_tx_addr,
  output logic [15:0]    c1_tx_mdata,
  output logic [511:0]   c1_tx_data,
  input  logic           c1_rx_wrrsp_valid,
  input  logic [15:0]    c1_rx_mdata,
  output logic           busy,
  output logic [31:0]    wr_seq,
  output logic           overflow,
  output logic           timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

  state_t state, next_state;

  logic [TW-1:0]  timer;
  logic [31:0]    act_job;
  logic           act_err;
  logic [127:0]   act_digest;
  logic           pend_valid;
  logic [31:0]    pend_job;
  logic           pend_err;
  logic [127:0]   pend_digest;

  logic [15:0]    exp_mdata;
  logic [511:0]   status_line;
  logic           rsp_hit, rsp_match, time_up, fire;
  logic           take_pend, take_done, store_pend, drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // ISSUE lasts two cycles when writing: one to decide, one with c1_tx_valid high.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (pend_valid || done_valid) next_state = ISSUE;
      ISSUE:    if (c1_tx_valid) next_state = WAIT_RSP;
                else if (dsm_base == '0) next_state = IDLE;
      WAIT_RSP: if (rsp_match || time_up) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    exp_mdata  = {MDATA_TAG, wr_seq[7:0]};
    rsp_hit    = c1_rx_wrrsp_valid && (c1_rx_mdata == exp_mdata);
    rsp_match  = (state == WAIT_RSP) && rsp_hit;
    time_up    = (state == WAIT_RSP) && !rsp_hit && (timer == TIMER_LAST);
    fire       = (state == ISSUE) && !c1_tx_valid && (dsm_base != '0) && !c1_tx_almfull;
    take_pend  = (state == IDLE) && pend_valid;
    take_done  = (state == IDLE) && !pend_valid && done_valid;
    store_pend = done_valid && !take_done && (!pend_valid || take_pend);
    drop       = done_valid && !take_done && !store_pend;
    busy       = (state != IDLE) || pend_valid;

    status_line          = '0;
    status_line[0]       = 1'b1;
    status_line[1]       = act_err;
    status_line[63:32]   = wr_seq + 32'd1;
    status_line[95:64]   = act_job;
    status_line[255:128] = act_digest;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_job     <= '0;
      act_err     <= 1'b0;
      act_digest  <= '0;
      pend_valid  <= 1'b0;
      pend_job    <= '0;
      pend_err    <= 1'b0;
      pend_digest <= '0;
      timer       <= '0;
      c1_tx_valid <= 1'b0;
      c1_tx_addr  <= '0;
      c1_tx_mdata <= '0;
      c1_tx_data  <= '0;
      wr_seq      <= '0;
      overflow    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      if (take_pend) begin
        act_job    <= pend_job;
        act_err    <= pend_err;
        act_digest <= pend_digest;
      end else if (take_done) begin
        act_job    <= done_job_id;
        act_err    <= done_error;
        act_digest <= done_digest;
      end

      if (store_pend) begin
        pend_valid  <= 1'b1;
        pend_job    <= done_job_id;
        pend_err    <= done_error;
        pend_digest <= done_digest;
      end else if (take_pend) begin
        pend_valid  <= 1'b0;
      end

      if (drop) overflow <= 1'b1;

      c1_tx_valid <= fire;
      if (fire) begin
        c1_tx_addr  <= dsm_base;
        c1_tx_mdata <= exp_mdata;
        c1_tx_data  <= status_line;
      end

      if (state == WAIT_RSP) timer <= timer + 1'b1;
      else                   timer <= '0;

      if (rsp_match) wr_seq  <= wr_seq + 32'd1;
      if (time_up)   timeout <= 1'b1;
    end
  end

endmodule
